// File: rtl/udp_echo_pkg.sv
// Shared types and widths for the UDP echo responder.
package udp_echo_pkg;

  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_DROP,
    ST_TX_HDR,
    ST_TX
  } state_t;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] length;
  } hdr_t;

endpackage

// File: rtl/udp_echo_if.sv
// UDP header + payload stream bundles: receive side from the stack, transmit side back to it.
interface udp_echo_rx_if;
  import udp_echo_pkg::*;

  logic              hdr_valid;
  logic              hdr_ready;
  logic [31:0]       ip_source_ip;
  logic [31:0]       ip_dest_ip;
  logic [15:0]       source_port;
  logic [15:0]       dest_port;
  logic [15:0]       length;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              tuser;

  modport master (
    output hdr_valid, ip_source_ip, ip_dest_ip, source_port, dest_port, length,
    output tdata, tkeep, tvalid, tlast, tuser,
    input  hdr_ready, tready
  );

  modport slave (
    input  hdr_valid, ip_source_ip, ip_dest_ip, source_port, dest_port, length,
    input  tdata, tkeep, tvalid, tlast, tuser,
    output hdr_ready, tready
  );
endinterface

interface udp_echo_tx_if;
  import udp_echo_pkg::*;

  logic              hdr_valid;
  logic              hdr_ready;
  logic [5:0]        ip_dscp;
  logic [1:0]        ip_ecn;
  logic [7:0]        ip_ttl;
  logic [31:0]       ip_source_ip;
  logic [31:0]       ip_dest_ip;
  logic [15:0]       source_port;
  logic [15:0]       dest_port;
  logic [15:0]       length;
  logic [15:0]       checksum;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              tuser;

  modport master (
    output hdr_valid, ip_dscp, ip_ecn, ip_ttl, ip_source_ip, ip_dest_ip,
    output source_port, dest_port, length, checksum,
    output tdata, tkeep, tvalid, tlast, tuser,
    input  hdr_ready, tready
  );

  modport slave (
    input  hdr_valid, ip_dscp, ip_ecn, ip_ttl, ip_source_ip, ip_dest_ip,
    input  source_port, dest_port, length, checksum,
    input  tdata, tkeep, tvalid, tlast, tuser,
    output hdr_ready, tready
  );
endinterface

// File: rtl/udp_echo_buf.sv
// Simple dual-port payload store: one write port, one registered read port (1-cycle latency).
module udp_echo_buf #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 72,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/udp_echo_responder.sv
// Store-and-forward UDP echo: buffers datagrams for LISTEN_PORT and returns them with addresses swapped.
// Statistics counters are built only when UDP_ECHO_STATS_EN is defined.
//
// state     | meaning
// ST_IDLE   | waiting for a receive header
// ST_RX     | storing payload beats of a matching datagram
// ST_DROP   | draining a non-matching or overflowing datagram
// ST_TX_HDR | presenting reply header, prefetching buffer word 0
// ST_TX     | replaying stored payload
module udp_echo_responder
  import udp_echo_pkg::*;
#(
  parameter logic [15:0] LISTEN_PORT = 16'd7,
  parameter int          DEPTH       = 256,
  parameter logic [7:0]  TTL         = 8'd64
) (
  input  logic          clk,
  input  logic          rst_n,
  udp_echo_rx_if.slave  s_udp,
  udp_echo_tx_if.master m_udp,
  output logic [15:0]   echo_count,
  output logic [15:0]   drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = KEEP_W + DATA_W;

  state_t        state, state_nx;
  hdr_t          hdr;
  logic [AW-1:0] wr_ptr, last_idx, out_idx, ram_raddr;
  logic          hdr_ready_q, rx_ready_q, m_hdr_valid_q, m_tvalid_q;
  logic [31:0]   r_src_ip, r_dst_ip;
  logic [15:0]   r_src_port, r_dst_port, r_len;
  logic [7:0]    r_ttl;
  logic          hdr_hs, rx_beat, tx_beat, tx_last, ovf, ram_we, ram_re;
  logic [BW-1:0] ram_rdata;

  assign hdr_hs  = s_udp.hdr_valid && hdr_ready_q;
  assign rx_beat = s_udp.tvalid && rx_ready_q;
  assign tx_beat = m_tvalid_q && m_udp.tready;
  assign tx_last = (out_idx == last_idx);
  assign ovf     = rx_beat && !s_udp.tlast && (wr_ptr == AW'(DEPTH - 1));
  assign ram_we  = (state == ST_RX) && rx_beat;

  udp_echo_buf #(.DEPTH(DEPTH), .WIDTH(BW)) u_buf (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata ({s_udp.tkeep, s_udp.tdata}),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_nx  = state;
    ram_re    = 1'b0;
    ram_raddr = out_idx + 1'b1;
    case (state)
      ST_IDLE:
        if (hdr_hs) state_nx = (s_udp.dest_port == LISTEN_PORT) ? ST_RX : ST_DROP;
      ST_RX:
        if (rx_beat) begin
          if (s_udp.tlast) state_nx = s_udp.tuser ? ST_IDLE : ST_TX_HDR;
          else if (ovf)    state_nx = ST_DROP;
        end
      ST_DROP:
        if (rx_beat && s_udp.tlast) state_nx = ST_IDLE;
      ST_TX_HDR: begin
        // Keep reading word 0 so it is on the RAM output the cycle after the handshake.
        ram_re    = 1'b1;
        ram_raddr = '0;
        if (m_hdr_valid_q && m_udp.hdr_ready) state_nx = ST_TX;
      end
      ST_TX:
        if (tx_beat) begin
          if (tx_last) state_nx = ST_IDLE;
          else         ram_re   = 1'b1;
        end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so reset drives them all low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      hdr           <= '0;
      wr_ptr        <= '0;
      last_idx      <= '0;
      out_idx       <= '0;
      hdr_ready_q   <= 1'b0;
      rx_ready_q    <= 1'b0;
      m_hdr_valid_q <= 1'b0;
      m_tvalid_q    <= 1'b0;
      r_src_ip      <= '0;
      r_dst_ip      <= '0;
      r_src_port    <= '0;
      r_dst_port    <= '0;
      r_len         <= '0;
      r_ttl         <= '0;
    end else begin
      state         <= state_nx;
      hdr_ready_q   <= (state_nx == ST_IDLE);
      rx_ready_q    <= (state_nx == ST_RX) || (state_nx == ST_DROP);
      m_hdr_valid_q <= (state_nx == ST_TX_HDR);
      m_tvalid_q    <= (state_nx == ST_TX);
      if (hdr_hs) begin
        hdr <= '{src_ip:   s_udp.ip_source_ip,
                 dst_ip:   s_udp.ip_dest_ip,
                 src_port: s_udp.source_port,
                 dst_port: s_udp.dest_port,
                 length:   s_udp.length};
        wr_ptr <= '0;
      end
      if (ram_we) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (s_udp.tlast) last_idx <= wr_ptr;
      end
      // Only matching datagrams get here, so the latched dest port equals LISTEN_PORT.
      if (state == ST_RX && state_nx == ST_TX_HDR) begin
        r_src_ip   <= hdr.dst_ip;
        r_dst_ip   <= hdr.src_ip;
        r_src_port <= hdr.dst_port;
        r_dst_port <= hdr.src_port;
        r_len      <= hdr.length;
        r_ttl      <= TTL;
      end
      if (state == ST_TX_HDR)                        out_idx <= '0;
      else if (state == ST_TX && tx_beat && !tx_last) out_idx <= out_idx + 1'b1;
    end
  end

  assign s_udp.hdr_ready = hdr_ready_q;
  assign s_udp.tready    = rx_ready_q;

  assign m_udp.hdr_valid    = m_hdr_valid_q;
  assign m_udp.ip_dscp      = '0;
  assign m_udp.ip_ecn       = '0;
  assign m_udp.ip_ttl       = r_ttl;
  assign m_udp.ip_source_ip = r_src_ip;
  assign m_udp.ip_dest_ip   = r_dst_ip;
  assign m_udp.source_port  = r_src_port;
  assign m_udp.dest_port    = r_dst_port;
  assign m_udp.length       = r_len;
  assign m_udp.checksum     = '0;
  assign m_udp.tdata        = m_tvalid_q ? ram_rdata[DATA_W-1:0] : '0;
  assign m_udp.tkeep        = m_tvalid_q ? ram_rdata[BW-1:DATA_W] : '0;
  assign m_udp.tvalid       = m_tvalid_q;
  assign m_udp.tlast        = m_tvalid_q && tx_last;
  assign m_udp.tuser        = 1'b0;

`ifdef UDP_ECHO_STATS_EN
  logic [15:0] echo_q, drop_q;
  logic        echo_inc, drop_inc;

  assign echo_inc = (state == ST_TX) && tx_beat && tx_last;
  assign drop_inc = ((state == ST_RX) && rx_beat && ((s_udp.tlast && s_udp.tuser) || ovf)) ||
                    ((state == ST_DROP) && rx_beat && s_udp.tlast && (hdr.dst_port != LISTEN_PORT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      echo_q <= '0;
      drop_q <= '0;
    end else begin
      if (echo_inc) echo_q <= echo_q + 16'd1;
      if (drop_inc) drop_q <= drop_q + 16'd1;
    end
  end

  assign echo_count = echo_q;
  assign drop_count = drop_q;
`else
  assign echo_count = 16'd0;
  assign drop_count = 16'd0;
`endif

endmodule
